// File: rtl/lcd_fifo_arbiter_if.sv
// lcd_fifo_arbiter_if: requester and FIFO-write bundle for lcd_fifo_arbiter.
// Carries timeout_flag only when LCD_FIFO_ARB_TIMEOUT_EN is defined.
interface lcd_fifo_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 69
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_in_ready;
  logic [3:0]                    fifo_fill_level;
  logic                          fifo_in_valid;
  logic [DATA_WIDTH-1:0]         fifo_in_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
`ifdef LCD_FIFO_ARB_TIMEOUT_EN
  logic                          timeout_flag;
  modport master (
    output req_valid, req_last, req_data, fifo_in_ready, fifo_fill_level,
    input  req_ready, fifo_in_valid, fifo_in_data, grant, busy, timeout_flag
  );
  modport slave (
    input  req_valid, req_last, req_data, fifo_in_ready, fifo_fill_level,
    output req_ready, fifo_in_valid, fifo_in_data, grant, busy, timeout_flag
  );
`else
  modport master (
    output req_valid, req_last, req_data, fifo_in_ready, fifo_fill_level,
    input  req_ready, fifo_in_valid, fifo_in_data, grant, busy
  );
  modport slave (
    input  req_valid, req_last, req_data, fifo_in_ready, fifo_fill_level,
    output req_ready, fifo_in_valid, fifo_in_data, grant, busy
  );
`endif
endinterface

// File: rtl/lcd_fifo_arbiter.sv
// lcd_fifo_arbiter: round-robin burst-locked arbiter feeding the LCD transfer FIFO.
// Optional idle-timeout release enabled by defining LCD_FIFO_ARB_TIMEOUT_EN.
module lcd_fifo_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 69,
  parameter int MAX_BURST   = 8,
  parameter int FILL_THRESH = 4,
  parameter int TIMEOUT     = 16
) (
  input logic              clk,
  input logic              reset,
  lcd_fifo_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_last_winner, w_winner, w_idx;
  logic [7:0]         r_beat_cnt;
  logic               w_busy, w_start, w_beat, w_release, w_timeout;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
      FILL_THRESH < 0 || FILL_THRESH > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("lcd_fifo_arbiter: parameter out of range");
  end

  // Descending scan so the lowest offset from last_winner wins.
  always_comb begin
    w_winner = r_last_winner;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last_winner) + k) % NUM_REQ);
      if (bus.req_valid[w_idx]) w_winner = w_idx;
    end
  end

  // While busy the granted index is always last_winner.
  assign w_busy            = r_state == BURST;
  assign w_start           = !w_busy && |bus.req_valid && bus.fifo_fill_level <= 4'(FILL_THRESH);
  assign bus.fifo_in_valid = w_busy && bus.req_valid[r_last_winner];
  assign bus.fifo_in_data  = w_busy ? bus.req_data[r_last_winner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.req_ready     = bus.fifo_in_ready ? r_grant : '0;
  assign bus.grant         = r_grant;
  assign bus.busy          = w_busy;
  assign w_beat            = bus.fifo_in_valid && bus.fifo_in_ready;
  assign w_release         = (w_beat && (bus.req_last[r_last_winner] ||
                              r_beat_cnt == 8'(MAX_BURST-1))) || w_timeout;

`ifdef LCD_FIFO_ARB_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       r_timeout_flag;
  assign w_timeout        = w_busy && !bus.req_valid[r_last_winner] && r_idle_cnt == 8'(TIMEOUT-1);
  assign bus.timeout_flag = r_timeout_flag;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt     <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (!w_busy || w_beat || w_release) r_idle_cnt <= '0;
      else if (!bus.req_valid[r_last_winner]) r_idle_cnt <= r_idle_cnt + 8'd1;
      if (w_timeout) r_timeout_flag <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_start ? BURST : (w_busy && w_release) ? IDLE : r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant       <= '0;
      r_last_winner <= IW'(NUM_REQ-1);
      r_beat_cnt    <= '0;
    end else if (w_start) begin
      r_grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
      r_last_winner <= w_winner;
      r_beat_cnt    <= '0;
    end else if (w_release) begin
      r_grant       <= '0;
      r_beat_cnt    <= '0;
    end else if (w_beat) begin
      r_beat_cnt    <= r_beat_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_lcd_fifo_arbiter.sv
// tb_lcd_fifo_arbiter: scoreboard bench for lcd_fifo_arbiter.
// Sources are per-requester queues; FIFO writes are checked against an expected queue.
module tb_lcd_fifo_arbiter;
  localparam int NR = 4;
  localparam int DW = 69;
  localparam int MB = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_fifo_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();
  lcd_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .FILL_THRESH(4), .TIMEOUT(TO))
    dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW:0]   src_q [NR][$];
  logic [DW-1:0] exp_q [$];
  logic [NR-1:0] exp_g [$];
  logic [NR-1:0] hs;
  int vectors = 0;
  int errors  = 0;

  function automatic logic [DW-1:0] beat(int r, int v);
    return {5'(r), 64'(v)};
  endfunction

  task automatic push(int r, int v, bit last, bit sb);
    src_q[r].push_back({last, beat(r, v)});
    if (sb) exp_q.push_back(beat(r, v));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Source side: pop after an accepted beat, then present the next one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && src_q[i].size() != 0) src_q[i].delete(0);
      if (src_q[i].size() != 0) begin
        bus.req_valid[i]           = 1'b1;
        bus.req_last[i]            = src_q[i][0][DW];
        bus.req_data[i*DW +: DW]   = src_q[i][0][DW-1:0];
      end else begin
        bus.req_valid[i]           = 1'b0;
        bus.req_last[i]            = 1'b0;
        bus.req_data[i*DW +: DW]   = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    hs = bus.req_valid & bus.req_ready;
    if (!reset && bus.fifo_in_valid && bus.fifo_in_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_beat unexpected: got %h, expected no beat", bus.fifo_in_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.fifo_in_data !== e) begin
          errors++;
          $display("FAIL fifo_beat data: got %h, expected %h", bus.fifo_in_data, e);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.fifo_in_ready   = 1'b1;
    bus.fifo_fill_level = 4'd0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    exp_g.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors += 5;
    if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b, expected 0", bus.grant); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    if (bus.fifo_in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.fifo_in_valid); end
    if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", bus.req_ready); end
    if (bus.fifo_in_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 0", bus.fifo_in_data); end
    do_reset();
    tick();
    vectors++;
    if (bus.grant !== '0) begin errors++; $display("FAIL idle_grant: got %b, expected 0", bus.grant); end
  endtask

  task automatic test_single_burst();
    logic [NR-1:0] want [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    push(2, 'h10, 0, 1);
    push(2, 'h11, 0, 1);
    push(2, 'h12, 1, 1);
    for (int t = 0; t < 5; t++) begin
      tick();
      vectors++;
      if (bus.grant !== want[t]) begin
        errors++;
        $display("FAIL single_grant cycle %0d: got %b, expected %b", t, bus.grant, want[t]);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] g, prev;
    int zr;
    bit first;
    int t;
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++) begin
        exp_g.push_back(NR'(1) << r);
        for (int k = 0; k < 2; k++) push(r, 2*b + k, k == 1, 1);
      end
    prev = '0; zr = 0; first = 1;
    for (t = 0; t < 200 && (exp_g.size() != 0 || bus.grant != '0); t++) begin
      tick();
      g = bus.grant;
      if (g != '0 && prev == '0) begin
        vectors++;
        if (exp_g.size() == 0) begin
          errors++; $display("FAIL rr_grant extra: got %b, expected none", g);
        end else if (g !== exp_g[0]) begin
          errors++; $display("FAIL rr_grant order: got %b, expected %b", g, exp_g[0]);
        end
        if (exp_g.size() != 0) exp_g.delete(0);
        if (!first) begin
          vectors++;
          if (zr != 1) begin errors++; $display("FAIL rr_gap: got %0d idle cycles, expected 1", zr); end
        end
        first = 0; zr = 0;
      end else if (g == '0) zr++;
      else if (g != prev) begin
        vectors++; errors++;
        $display("FAIL rr_switch: got %b after %b, expected idle gap", g, prev);
      end
      prev = g;
    end
    vectors++;
    if (exp_g.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d grants, %0d beats left, expected 0", exp_g.size(), exp_q.size());
    end
  endtask

  task automatic test_max_burst();
    logic [NR-1:0] prev;
    int rises, len[3];
    do_reset();
    for (int v = 0; v < 20; v++) push(1, 'h100 + v, 0, 1);
    prev = '0; rises = 0; len = '{0, 0, 0};
    for (int t = 0; t < 150 && exp_q.size() != 0; t++) begin
      tick();
      if (bus.grant != '0 && prev == '0) begin
        rises++;
        vectors++;
        if (bus.grant !== 4'b0010) begin errors++; $display("FAIL mb_grant: got %b, expected 0010", bus.grant); end
      end
      if (bus.fifo_in_valid && bus.fifo_in_ready && rises >= 1 && rises <= 3) len[rises-1]++;
      prev = bus.grant;
    end
    vectors += 4;
    if (rises != 3) begin errors++; $display("FAIL mb_grants: got %0d, expected 3", rises); end
    if (len[0] != MB) begin errors++; $display("FAIL mb_len0: got %0d, expected %0d", len[0], MB); end
    if (len[1] != MB) begin errors++; $display("FAIL mb_len1: got %0d, expected %0d", len[1], MB); end
    if (len[2] != 4) begin errors++; $display("FAIL mb_len2: got %0d, expected 4", len[2]); end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mb_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_threshold();
    do_reset();
    bus.fifo_fill_level = 4'd6;
    push(0, 'h55, 1, 1);
    for (int t = 0; t < 3; t++) begin
      tick();
      vectors++;
      if (bus.grant !== '0) begin errors++; $display("FAIL thr_level6: got %b, expected 0000", bus.grant); end
    end
    bus.fifo_fill_level = 4'd5;
    tick();
    vectors++;
    if (bus.grant !== '0) begin errors++; $display("FAIL thr_level5: got %b, expected 0000", bus.grant); end
    bus.fifo_fill_level = 4'd4;
    tick();
    vectors++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL thr_level4: got %b, expected 0001", bus.grant); end
    bus.fifo_fill_level = 4'd0;
    for (int t = 0; t < 6 && exp_q.size() != 0; t++) tick();
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL thr_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int v = 0; v < 4; v++) push(0, 'h200 + v, v == 3, 1);
    for (int t = 0; t < 10 && bus.grant == '0; t++) tick();
    vectors++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b, expected 0001", bus.grant); end
    bus.fifo_in_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      vectors += 3;
      if (bus.req_ready !== '0) begin errors++; $display("FAIL bp_ready: got %b, expected 0000", bus.req_ready); end
      if (bus.fifo_in_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", bus.fifo_in_valid); end
      if (bus.fifo_in_data !== beat(0, 'h200)) begin
        errors++; $display("FAIL bp_hold: got %h, expected %h", bus.fifo_in_data, beat(0, 'h200));
      end
    end
    bus.fifo_in_ready = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) tick();
    tick();
    vectors += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d beats left, expected 0", exp_q.size()); end
    if (bus.grant !== '0) begin errors++; $display("FAIL bp_release: got %b, expected 0000", bus.grant); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int v = 0; v < 5; v++) push(3, 'h400 + v, v == 4, 1);
    for (int t = 0; t < 10 && bus.grant == '0; t++) tick();
    tick();
    vectors++;
    if (bus.grant !== 4'b1000) begin errors++; $display("FAIL ar_grant: got %b, expected 1000", bus.grant); end
    #3;
    reset = 1'b1;
    #1;
    vectors += 4;
    if (bus.grant !== '0) begin errors++; $display("FAIL ar_grant_drop: got %b, expected 0000", bus.grant); end
    if (bus.fifo_in_valid !== 1'b0) begin errors++; $display("FAIL ar_valid_drop: got %b, expected 0", bus.fifo_in_valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy_drop: got %b, expected 0", bus.busy); end
    if (bus.req_ready !== '0) begin errors++; $display("FAIL ar_ready_drop: got %b, expected 0000", bus.req_ready); end
    do_reset();
  endtask

`ifdef LCD_FIFO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    do_reset();
    push(3, 'h300, 0, 1);
    for (int t = 0; t < 10 && bus.grant == '0; t++) tick();
    vectors += 2;
    if (bus.grant !== 4'b1000) begin errors++; $display("FAIL to_grant: got %b, expected 1000", bus.grant); end
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL to_flag_pre: got %b, expected 0", bus.timeout_flag); end
    held = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.grant == '0) break;
      held++;
    end
    vectors += 3;
    if (held != TO) begin errors++; $display("FAIL to_hold: got %0d cycles, expected %0d", held, TO); end
    if (bus.timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag_set: got %b, expected 1", bus.timeout_flag); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL to_drain: %0d beats left, expected 0", exp_q.size()); end
    tick();
    vectors++;
    if (bus.timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag_sticky: got %b, expected 1", bus.timeout_flag); end
    do_reset();
    vectors++;
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL to_flag_clear: got %b, expected 0", bus.timeout_flag); end
  endtask
`endif

  initial begin
    reset               = 1'b1;
    hs                  = '0;
    bus.req_valid       = '0;
    bus.req_last        = '0;
    bus.req_data        = '0;
    bus.fifo_in_ready   = 1'b1;
    bus.fifo_fill_level = 4'd0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_threshold();
    test_backpressure();
    test_async_reset();
`ifdef LCD_FIFO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
